checkpoint_seq_monitor: RTL

Parametrised, clocked checker that watches a WIDTH-bit checkpoint bus driven by firmware on mprj_io and matches it against an ordered table of up to DEPTH expected values. It adds glitch filtering, optional strict mismatch detection, a programmable inter-checkpoint timeout and per-match reporting. It sits in the testbench beside the UART model. It replaces ad-hoc chains of wait() statements and global cycle-count timeouts.

---
 rtl/checkpoint_seq_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/checkpoint_seq_monitor.sv
// rtl/checkpoint_seq_monitor.sv - ordered checkpoint-bus sequence checker with glitch filter and timeout
module checkpoint_seq_monitor #(
  parameter  int WIDTH         = 16,
  parameter  int DEPTH         = 32,
  parameter  int TIMEOUT_W     = 24,
  parameter  int STABLE_CYCLES = 2,
  parameter  int STRICT        = 0,
  localparam int AW            = $clog2(DEPTH),
  localparam int LW            = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic [WIDTH-1:0]     checkbits,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [WIDTH-1:0]     load_data,
  input  logic [LW-1:0]        seq_len,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 start,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic                 match_pulse,
  output logic [AW-1:0]        match_idx,
  output logic [WIDTH-1:0]     fail_value
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_QUAL = CW'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     exp_tbl [DEPTH];
  logic [WIDTH-1:0]     prev;
  logic [CW-1:0]        stable_cnt;
  logic                 ev;
  logic [WIDTH-1:0]     ev_val;
  logic [AW-1:0]        idx;
  logic [TIMEOUT_W-1:0] timer;
  logic [LW-1:0]        len_r;
  logic [TIMEOUT_W-1:0] lim_r;
  logic [WIDTH-1:0]     last_ok;

  logic                 same;
  logic [CW-1:0]        cnt_next;
  logic                 qual;
  logic                 hit;
  logic                 is_last;
  logic                 expired;

  // One qualify event per stable run: fires only on the transition into CNT_QUAL.
  always_comb begin
    same = (checkbits == prev);
    if (!same) begin
      cnt_next = '0;
    end else if (stable_cnt == CNT_SAT) begin
      cnt_next = CNT_SAT;
    end else begin
      cnt_next = stable_cnt + 1'b1;
    end
    qual = (cnt_next == CNT_QUAL) && !(same && (stable_cnt == CNT_QUAL));
  end

  assign hit     = ev && (ev_val == exp_tbl[idx]);
  assign is_last = ((LW'(idx) + LW'(1)) == len_r);
  assign expired = (lim_r != '0) && (timer == lim_r - 1'b1);
  assign busy    = (state == ST_ARMED);

  always_ff @(posedge clock) begin
    if (load_en && (state != ST_ARMED)) begin
      exp_tbl[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      match_pulse <= 1'b0;
      match_idx   <= '0;
      fail_value  <= '0;
      prev        <= '0;
      stable_cnt  <= '0;
      ev          <= 1'b0;
      ev_val      <= '0;
      idx         <= '0;
      timer       <= '0;
      len_r       <= '0;
      lim_r       <= '0;
      last_ok     <= '0;
    end else begin
      match_pulse <= 1'b0;
      if (start && (state != ST_ARMED)) begin
        state      <= ST_ARMED;
        pass       <= 1'b0;
        fail       <= 1'b0;
        timeout    <= 1'b0;
        match_idx  <= '0;
        fail_value <= '0;
        len_r      <= seq_len;
        lim_r      <= timeout_limit;
        idx        <= '0;
        timer      <= '0;
        prev       <= checkbits;
        stable_cnt <= '0;
        last_ok    <= checkbits;
        ev         <= 1'b0;
      end else begin
        prev       <= checkbits;
        stable_cnt <= cnt_next;
        ev         <= qual;
        ev_val     <= checkbits;
        if (state == ST_ARMED) begin
          // Match beats timeout expiry on the same edge.
          if (len_r == '0) begin
            state <= ST_PASS;
            pass  <= 1'b1;
          end else if (hit) begin
            match_pulse <= 1'b1;
            match_idx   <= idx;
            last_ok     <= ev_val;
            timer       <= '0;
            idx         <= idx + 1'b1;
            if (is_last) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end
          end else if ((STRICT != 0) && ev && (ev_val != last_ok)) begin
            state      <= ST_FAIL;
            fail       <= 1'b1;
            fail_value <= ev_val;
          end else if (expired) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      end
    end
  end

endmodule
